// File: rtl/snoop_responder_if.sv
// Snoop responder bus bundle: snoop request/result, L2 lookup,
// L2 update, writeback, L1 invalidate, protocol error and hit counters.
//   slave  : responder side (snoop_responder)
//   master : environment side (snoop source, L2 tags, memory, L1)
interface snoop_responder_if #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int INDEX_W  = 14,
  parameter int WAY_W    = 3
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

  logic              snp_valid;
  logic              snp_ready;
  logic [1:0]        snp_op;
  logic [ADDR_W-1:0] snp_addr;

  logic              snp_res_valid;
  logic [1:0]        snp_res;

  logic               lk_req;
  logic [INDEX_W-1:0] lk_index;
  logic [TAG_W-1:0]   lk_tag;
  logic               lk_ack;
  logic               lk_hit;
  logic [WAY_W-1:0]   lk_way;
  logic [1:0]         lk_state;

  logic               upd_valid;
  logic [INDEX_W-1:0] upd_index;
  logic [WAY_W-1:0]   upd_way;
  logic [1:0]         upd_state;

  logic              wb_req;
  logic [ADDR_W-1:0] wb_addr;
  logic              wb_ack;

  logic              l1_inv_valid;
  logic [ADDR_W-1:0] l1_inv_addr;

  logic              proto_err;
  logic [15:0]       hit_cnt;
  logic [15:0]       hitm_cnt;

  modport slave (
    input  snp_valid, snp_op, snp_addr,
    input  lk_ack, lk_hit, lk_way, lk_state,
    input  wb_ack,
    output snp_ready, snp_res_valid, snp_res,
    output lk_req, lk_index, lk_tag,
    output upd_valid, upd_index, upd_way, upd_state,
    output wb_req, wb_addr,
    output l1_inv_valid, l1_inv_addr,
    output proto_err, hit_cnt, hitm_cnt
  );

  modport master (
    output snp_valid, snp_op, snp_addr,
    output lk_ack, lk_hit, lk_way, lk_state,
    output wb_ack,
    input  snp_ready, snp_res_valid, snp_res,
    input  lk_req, lk_index, lk_tag,
    input  upd_valid, upd_index, upd_way, upd_state,
    input  wb_req, wb_addr,
    input  l1_inv_valid, l1_inv_addr,
    input  proto_err, hit_cnt, hitm_cnt
  );
endinterface

// File: rtl/snoop_responder.sv
// Snoop responder: accepts one snoop, looks up the L2 line, answers
// NoHIT/HIT/HITM, then runs writeback, L1 invalidate and state update.
// Ports: clk, rst (async active-high), bus (snoop_responder_if.slave).
module snoop_responder #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int INDEX_W  = 14,
  parameter int WAY_W    = 3
) (
  input logic              clk,
  input logic              rst,
  snoop_responder_if.slave bus
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_RFO   = 2'd2;
  localparam logic [1:0] OP_INV   = 2'd3;

  localparam logic [1:0] ST_I = 2'd0;
  localparam logic [1:0] ST_S = 2'd1;
  localparam logic [1:0] ST_E = 2'd2;
  localparam logic [1:0] ST_M = 2'd3;

  localparam logic [1:0] RES_NOHIT = 2'd0;
  localparam logic [1:0] RES_HIT   = 2'd1;
  localparam logic [1:0] RES_HITM  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_RESULT,
    S_WB,
    S_INV0,
    S_INV1,
    S_UPD
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WAY_W-1:0]  way_q, way_d;
  logic [1:0]        res_q, res_d;
  logic [1:0]        nst_q, nst_d;
  logic              wb_q, wb_d;
  logic              inv_q, inv_d;
  logic              upd_q, upd_d;
  logic              perr_q, perr_d;
  logic [15:0]       hit_cnt_q, hit_cnt_d;
  logic [15:0]       hitm_cnt_q, hitm_cnt_d;

  logic [1:0] eff;
  logic [1:0] dec_res;
  logic [1:0] dec_nst;
  logic       dec_wb;
  logic       dec_inv;
  logic       dec_upd;
  logic       dec_perr;

  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic [ADDR_W-1:0]  line_base;
  logic [ADDR_W-1:0]  line_half;

  assign index     = addr_q[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign tag       = addr_q[ADDR_W-1:OFFSET_W+INDEX_W];
  assign line_base = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign line_half = line_base
                   | (ADDR_W'(1) << (OFFSET_W - 1));

  // Action decode from the lookup response; a miss looks like state I.
  always_comb begin
    eff      = bus.lk_hit ? bus.lk_state : ST_I;
    dec_res  = RES_NOHIT;
    dec_nst  = ST_I;
    dec_wb   = 1'b0;
    dec_inv  = 1'b0;
    dec_upd  = 1'b0;
    dec_perr = 1'b0;
    unique case (op_q)
      OP_READ: begin
        dec_res = (eff == ST_M) ? RES_HITM :
                  (eff == ST_I) ? RES_NOHIT : RES_HIT;
        dec_wb  = (eff == ST_M);
        dec_upd = (eff == ST_E) || (eff == ST_M);
        dec_nst = ST_S;
      end
      OP_WRITE: begin
        // Another agent writing a line we hold is illegal.
        dec_perr = bus.lk_hit;
      end
      OP_RFO: begin
        dec_res = (eff == ST_M) ? RES_HITM :
                  (eff == ST_I) ? RES_NOHIT : RES_HIT;
        dec_wb  = (eff == ST_M);
        dec_inv = (eff != ST_I);
        dec_upd = (eff != ST_I);
      end
      OP_INV: begin
        // Dirty/exclusive data is discarded, flagged as an error.
        dec_res  = (eff == ST_I) ? RES_NOHIT : RES_HIT;
        dec_perr = (eff == ST_E) || (eff == ST_M);
        dec_inv  = (eff != ST_I);
        dec_upd  = (eff != ST_I);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    way_d      = way_q;
    res_d      = res_q;
    nst_d      = nst_q;
    wb_d       = wb_q;
    inv_d      = inv_q;
    upd_d      = upd_q;
    perr_d     = perr_q;
    hit_cnt_d  = hit_cnt_q;
    hitm_cnt_d = hitm_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.snp_valid) begin
          op_d    = bus.snp_op;
          addr_d  = bus.snp_addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (bus.lk_ack) begin
          way_d   = bus.lk_way;
          res_d   = dec_res;
          nst_d   = dec_nst;
          wb_d    = dec_wb;
          inv_d   = dec_inv;
          upd_d   = dec_upd;
          perr_d  = dec_perr;
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        if (res_q == RES_HIT && hit_cnt_q != 16'hFFFF)
          hit_cnt_d = hit_cnt_q + 16'd1;
        if (res_q == RES_HITM && hitm_cnt_q != 16'hFFFF)
          hitm_cnt_d = hitm_cnt_q + 16'd1;
        state_d = wb_q  ? S_WB   :
                  inv_q ? S_INV0 :
                  upd_q ? S_UPD  : S_IDLE;
      end
      S_WB: begin
        if (bus.wb_ack)
          state_d = inv_q ? S_INV0 :
                    upd_q ? S_UPD  : S_IDLE;
      end
      S_INV0: state_d = S_INV1;
      S_INV1: state_d = upd_q ? S_UPD : S_IDLE;
      S_UPD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= 2'd0;
      addr_q     <= '0;
      way_q      <= '0;
      res_q      <= RES_NOHIT;
      nst_q      <= ST_I;
      wb_q       <= 1'b0;
      inv_q      <= 1'b0;
      upd_q      <= 1'b0;
      perr_q     <= 1'b0;
      hit_cnt_q  <= 16'd0;
      hitm_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      way_q      <= way_d;
      res_q      <= res_d;
      nst_q      <= nst_d;
      wb_q       <= wb_d;
      inv_q      <= inv_d;
      upd_q      <= upd_d;
      perr_q     <= perr_d;
      hit_cnt_q  <= hit_cnt_d;
      hitm_cnt_q <= hitm_cnt_d;
    end
  end

  // Outputs are state decodes, so reset clears them immediately.
  logic in_res, in_wb, in_inv0, in_inv1, in_upd;
  assign in_res  = (state_q == S_RESULT);
  assign in_wb   = (state_q == S_WB);
  assign in_inv0 = (state_q == S_INV0);
  assign in_inv1 = (state_q == S_INV1);
  assign in_upd  = (state_q == S_UPD);

  assign bus.snp_ready     = (state_q == S_IDLE);
  assign bus.snp_res_valid = in_res;
  assign bus.snp_res       = in_res ? res_q : RES_NOHIT;
  assign bus.proto_err     = in_res & perr_q;

  assign bus.lk_req   = (state_q == S_LOOKUP);
  assign bus.lk_index = index;
  assign bus.lk_tag   = tag;

  assign bus.wb_req  = in_wb;
  assign bus.wb_addr = in_wb ? line_base : '0;

  assign bus.l1_inv_valid = in_inv0 | in_inv1;
  assign bus.l1_inv_addr  = in_inv0 ? line_base :
                            in_inv1 ? line_half : '0;

  assign bus.upd_valid = in_upd;
  assign bus.upd_index = in_upd ? index : '0;
  assign bus.upd_way   = in_upd ? way_q : '0;
  assign bus.upd_state = in_upd ? nst_q : ST_I;

  assign bus.hit_cnt  = hit_cnt_q;
  assign bus.hitm_cnt = hitm_cnt_q;
endmodule
